wdt_sleep_ctrl: RTL and testbench
=================================

# wdt_sleep_ctrl

Watchdog, sleep and prescaler controller for the PIC16C5x core. Owns the 8-bit prescaler and shares it between the watchdog timer and TMR0 according to the OPTION register. Sequences the SLEEP and CLRWDT instructions and generates the watchdog-timeout reset request. Maintains the STATUS TO/PD bits. Sits beside ControlUnit: consumes its Q4 execute decodes and stalls it through `core_hold`.

## Interface
- `WDT_BASE`, default 18000: clk cycles per watchdog base tick; must be at least 2.
- `RST_HOLD`, default 4: cycles that `core_rst_req` stays high after a timeout; must be at least 1.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low; acts as power-on/MCLR reset.
- `wdt_en` in 1: watchdog enable (configuration fuse); static while running.
- `ex_clrwdt` in 1: one-cycle pulse while the execute state is EX_Q4_CLRWDT.
- `ex_sleep` in 1: one-cycle pulse while the execute state is EX_Q4_SLEEP.
- `option_we` in 1: one-cycle pulse while the execute state is EX_Q4_OPTION.
- `option_in` in 6: W[5:0]; bit 3 is PSA, bits [2:0] are PS.
- `tmr0_tick` in 1: TMR0 source event (instruction-cycle tick or synchronized T0CKI edge).
- `tmr0_inc` out 1: TMR0 increment pulse.
- `core_hold` out 1: freezes fetch/execute state advance.
- `core_rst_req` out 1: reset request to the core (WDT reset).
- `status_to` out 1: STATUS.TO.
- `status_pd` out 1: STATUS.PD.
- `prescale_cnt` out 8: live prescaler count, for debug and the bench.

## Operation
- Reset values:
  - OPTION shadow: PSA=1, PS=3'b111.
  - Counters: 0.
  - `status_to` = 1, `status_pd` = 1.
  - `core_hold` = 0, `core_rst_req` = 0, `tmr0_inc` = 0.
  - FSM state: RUN.
- Base counter:
  - Runs only when `wdt_en`=1. Counts 0..WDT_BASE-1 and wraps.
  - `base_tick` is asserted when the count equals WDT_BASE-1.
- Prescaler assignment:
  - PSA=1 (assigned to WDT): the prescaler counts `base_tick`s. Ratio is 2^PS (1..128). `tmr0_inc` = `tmr0_tick`, combinational bypass.
  - PSA=0 (assigned to TMR0): the prescaler counts `tmr0_tick`s. Ratio is 2^(PS+1) (2..256). `tmr0_inc` pulses on the tick that completes the ratio. The WDT ratio is 1:1, so every `base_tick` is a timeout.
- Prescaler roll-over: a terminal event clears `prescale_cnt` to 0.
- Timeout: `wdt_to` is the terminal `base_tick` of the WDT path.
- Clear events, `ex_clrwdt` or `ex_sleep`:
  - Clear the base counter.
  - Clear the prescaler only if PSA=1.
  - Set TO=1. PD=1 for CLRWDT, PD=0 for SLEEP.
- `option_we`: loads the shadow register and clears the prescaler and the base counter.
- FSM states:
  - RUN, `ex_sleep` -> SLEEP; `core_hold`=1 from the next cycle.
  - RUN, `wdt_to` -> RESET. Sets TO=0; PD unchanged.
  - SLEEP, `wdt_to` -> RESET. Sets TO=0; PD stays 0 (wake-up from sleep).
  - SLEEP with `wdt_en`=0: stays in SLEEP until `rst_n`.
  - RESET: `core_rst_req`=1 and `core_hold`=1 for RST_HOLD cycles, then -> RUN.
- During RESET: counters held at 0; ex/option inputs ignored; TO/PD preserved. Only `rst_n` forces TO=PD=1.
- `tmr0_inc` in SLEEP or RESET: forced to 0.
- Simultaneous events:
  - A clear event (`ex_clrwdt`, `ex_sleep`, `option_we`) in the same cycle as `wdt_to`: the clear wins, with no reset.
  - `ex_sleep` and `ex_clrwdt` together: treated as SLEEP.
  - `option_we` and a prescaler terminal event together: the write wins and no `tmr0_inc` is issued.
- `rst_n` low in any state: synchronous return to all reset values the next edge.

## Timing
- All registered outputs change on `posedge clk`. `tmr0_inc` is combinational from `tmr0_tick` only when PSA=1.
- SLEEP entry: `ex_sleep` high at edge N; `core_hold`=1 and `status_pd`=0 after edge N.
- Timeout: `wdt_to` at edge N; `core_rst_req` is high after edges N..N+RST_HOLD-1 and low after N+RST_HOLD.
- Timeout distance with PSA=1: the first timeout comes WDT_BASE·2^PS enabled cycles after a clear. The clear cycle itself counts 0.
- `status_to`/`status_pd` update one edge after the causing event.

## Structure
- Shared additions to `define.v`:
  - FSM encoding `WS_RUN`/`WS_SLEEP`/`WS_RESET`.
  - `OPT_PSA_BIT`=3 and `OPT_PS_MSB`=2.
  - `PRESCALE_WIDTH`=8.
- One sub-module, `prescaler_unit`:
  - Inputs: `clk`, `rst_n`, `clr`, `psa`, `ps`, `tmr0_tick`, `base_tick`.
  - Outputs: `cnt`, `wdt_to`, `tmr0_inc`.
  - The top holds the FSM, the base counter and TO/PD.

## Test plan
- Reset, then `wdt_en`=1, WDT_BASE=4, PSA=1, PS=2, no CLRWDT -> `wdt_to` after 16 cycles. `core_rst_req` high for 4 cycles. TO=0, PD=1.
- Same configuration with `ex_clrwdt` every 12 cycles for 200 cycles -> `core_rst_req` never asserted. TO=1, PD=1.
- `ex_sleep` -> `core_hold`=1 next cycle, PD=0. 16 cycles later: reset request, TO=0, PD=0, then `core_hold` drops after RST_HOLD.
- `option_we` with `option_in`=6'b000001 (PSA=0, PS=1), 16 `tmr0_tick`s -> 4 `tmr0_inc` pulses. With WDT_BASE=4, the timeout comes every 4 cycles without clears.
- `ex_clrwdt` in the exact cycle of `wdt_to` -> no reset, counters cleared. `rst_n` low mid-RESET -> all outputs at reset values next edge.

Source files
------------

// File: rtl/wdt_sleep_ctrl_pkg.sv
// Shared encodings for the watchdog/sleep/prescaler slice of the PIC16C5x core.
// Holds the FSM state type, OPTION field positions and the prescaler ratio helper.
package wdt_sleep_ctrl_pkg;

   localparam int PRESCALE_WIDTH = 8;
   localparam int OPT_PSA_BIT    = 3;
   localparam int OPT_PS_MSB     = 2;

   typedef enum logic [1:0] {
      WS_RUN   = 2'd0,
      WS_SLEEP = 2'd1,
      WS_RESET = 2'd2
   } ws_state_e;

   // Terminal count for the current assignment: 2^PS-1 on the WDT side, 2^(PS+1)-1 on TMR0.
   function automatic logic [PRESCALE_WIDTH-1:0] prescale_limit(
      input logic                psa,
      input logic [OPT_PS_MSB:0] ps
   );
      logic [3:0]              shamt;
      logic [PRESCALE_WIDTH:0] span;
      logic [PRESCALE_WIDTH:0] last;
      shamt = psa ? {1'b0, ps} : ({1'b0, ps} + 4'd1);
      span  = (PRESCALE_WIDTH+1)'(1) << shamt;
      last  = span - (PRESCALE_WIDTH+1)'(1);
      return last[PRESCALE_WIDTH-1:0];
   endfunction

endpackage

// File: rtl/wdt_sleep_ctrl_prescaler_unit.sv
// Shared 8-bit prescaler: divides base ticks for the WDT (PSA=1) or TMR0 ticks (PSA=0).
// The side that does not own the prescaler sees its event 1:1.
module prescaler_unit
   import wdt_sleep_ctrl_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clr,
   input  logic                      psa,
   input  logic [OPT_PS_MSB:0]       ps,
   input  logic                      tmr0_tick,
   input  logic                      base_tick,
   output logic [PRESCALE_WIDTH-1:0] cnt,
   output logic                      wdt_to,
   output logic                      tmr0_inc
);

   logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
   logic                      evt;
   logic                      terminal;

   // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
   always_comb begin
      evt      = psa ? base_tick : tmr0_tick;
      terminal = evt && (cnt_q == prescale_limit(psa, ps));
      wdt_to   = psa ? terminal : base_tick;
      // A clear in the same cycle as the TMR0 terminal count swallows the increment.
      tmr0_inc = psa ? tmr0_tick : (terminal && !clr);
      cnt_d    = cnt_q;
      if (clr || terminal) begin
         cnt_d = '0;
      end else if (evt) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // NOTE: reset is synchronous (sampled on the clock edge) and state updates use non-blocking assignments.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/wdt_sleep_ctrl.sv
// Watchdog, SLEEP and prescaler controller: base counter, TO/PD bits, WDT reset request
// and core hold sequencing, with the shared prescaler in prescaler_unit.
module wdt_sleep_ctrl
   import wdt_sleep_ctrl_pkg::*;
#(
   parameter int WDT_BASE = 18000,
   parameter int RST_HOLD = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      wdt_en,
   input  logic                      ex_clrwdt,
   input  logic                      ex_sleep,
   input  logic                      option_we,
   input  logic [5:0]                option_in,
   input  logic                      tmr0_tick,
   output logic                      tmr0_inc,
   output logic                      core_hold,
   output logic                      core_rst_req,
   output logic                      status_to,
   output logic                      status_pd,
   output logic [PRESCALE_WIDTH-1:0] prescale_cnt
);

   localparam int BASE_W = $clog2(WDT_BASE);
   localparam int HOLD_W = $clog2(RST_HOLD + 1);

   ws_state_e            state_q;
   logic [BASE_W-1:0]    base_q, base_d;
   logic [HOLD_W-1:0]    hold_cnt_q;
   logic [OPT_PSA_BIT:0] opt_q;
   logic                 hold_q, rst_req_q, to_q, pd_q;

   logic in_run, in_reset, clr_evt, base_tick, pre_clr;
   logic pu_wdt_to, pu_tmr0_inc, wdt_to;
   logic opt_unused;

   // T0CS/T0SE belong to the TMR0 clock-select path, not to this block.
   assign opt_unused = ^option_in[5:4];

   // The core is frozen outside RUN, so execute decodes are only honoured there.
   assign in_run    = (state_q == WS_RUN);
   assign in_reset  = (state_q == WS_RESET);
   assign clr_evt   = in_run && (ex_clrwdt || ex_sleep || option_we);
   assign base_tick = wdt_en && !in_reset && (base_q == BASE_W'(WDT_BASE - 1));
   assign pre_clr   = in_reset || (in_run && option_we)
                    || (in_run && (ex_clrwdt || ex_sleep) && opt_q[OPT_PSA_BIT]);
   assign wdt_to    = pu_wdt_to && !clr_evt;

   always_comb begin
      base_d = base_q;
      if (in_reset || clr_evt) begin
         base_d = '0;
      end else if (wdt_en) begin
         base_d = base_tick ? '0 : base_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         base_q <= '0;
         opt_q  <= '1;
      end else begin
         base_q <= base_d;
         if (in_run && option_we) begin
            opt_q <= option_in[OPT_PSA_BIT:0];
         end
      end
   end

   prescaler_unit u_prescaler (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (pre_clr),
      .psa       (opt_q[OPT_PSA_BIT]),
      .ps        (opt_q[OPT_PS_MSB:0]),
      .tmr0_tick (tmr0_tick),
      .base_tick (base_tick),
      .cnt       (prescale_cnt),
      .wdt_to    (pu_wdt_to),
      .tmr0_inc  (pu_tmr0_inc)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= WS_RUN;
         hold_cnt_q <= '0;
         hold_q     <= 1'b0;
         rst_req_q  <= 1'b0;
         to_q       <= 1'b1;
         pd_q       <= 1'b1;
      end else begin
         case (state_q)
            WS_RUN: begin
               if (ex_sleep) begin
                  state_q <= WS_SLEEP;
                  hold_q  <= 1'b1;
                  to_q    <= 1'b1;
                  pd_q    <= 1'b0;
               end else if (ex_clrwdt) begin
                  to_q <= 1'b1;
                  pd_q <= 1'b1;
               end else if (wdt_to) begin
                  state_q    <= WS_RESET;
                  hold_cnt_q <= '0;
                  hold_q     <= 1'b1;
                  rst_req_q  <= 1'b1;
                  to_q       <= 1'b0;
               end
            end
            WS_SLEEP: begin
               if (wdt_to) begin
                  state_q    <= WS_RESET;
                  hold_cnt_q <= '0;
                  rst_req_q  <= 1'b1;
                  to_q       <= 1'b0;
               end
            end
            WS_RESET: begin
               if (hold_cnt_q == HOLD_W'(RST_HOLD - 1)) begin
                  state_q   <= WS_RUN;
                  hold_q    <= 1'b0;
                  rst_req_q <= 1'b0;
               end else begin
                  hold_cnt_q <= hold_cnt_q + 1'b1;
               end
            end
            default: begin
               state_q   <= WS_RUN;
               hold_q    <= 1'b0;
               rst_req_q <= 1'b0;
            end
         endcase
      end
   end

   assign tmr0_inc     = in_run && pu_tmr0_inc;
   assign core_hold    = hold_q;
   assign core_rst_req = rst_req_q;
   assign status_to    = to_q;
   assign status_pd    = pd_q;

endmodule

// File: tb/tb_wdt_sleep_ctrl.sv
// Directed bench for wdt_sleep_ctrl with WDT_BASE=4, RST_HOLD=4; inputs change and
// outputs are sampled just after the falling edge.
module tb_wdt_sleep_ctrl;

   localparam int WDT_BASE = 4;
   localparam int RST_HOLD = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wdt_en = 1'b1;
   logic       ex_clrwdt = 1'b0;
   logic       ex_sleep = 1'b0;
   logic       option_we = 1'b0;
   logic [5:0] option_in = 6'b0;
   logic       tmr0_tick = 1'b0;
   logic       tmr0_inc, core_hold, core_rst_req, status_to, status_pd;
   logic [7:0] prescale_cnt;

   int n_checks = 0;
   int n_errors = 0;

   wdt_sleep_ctrl #(.WDT_BASE(WDT_BASE), .RST_HOLD(RST_HOLD)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .wdt_en       (wdt_en),
      .ex_clrwdt    (ex_clrwdt),
      .ex_sleep     (ex_sleep),
      .option_we    (option_we),
      .option_in    (option_in),
      .tmr0_tick    (tmr0_tick),
      .tmr0_inc     (tmr0_inc),
      .core_hold    (core_hold),
      .core_rst_req (core_rst_req),
      .status_to    (status_to),
      .status_pd    (status_pd),
      .prescale_cnt (prescale_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic hold, input logic req,
                             input logic to, input logic pd);
      check({tag, ".hold"}, 32'(core_hold), 32'(hold));
      check({tag, ".rst_req"}, 32'(core_rst_req), 32'(req));
      check({tag, ".to"}, 32'(status_to), 32'(to));
      check({tag, ".pd"}, 32'(status_pd), 32'(pd));
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: observed=running expected=finished");
      $fatal(1, "bench time limit reached");
   end

   initial begin
      int  n_inc;
      logic saw_req;

      // Power-on reset values
      cyc(3);
      check_outs("reset", 1'b0, 1'b0, 1'b1, 1'b1);
      check("reset.prescale_cnt", 32'(prescale_cnt), 32'd0);
      check("reset.tmr0_inc", 32'(tmr0_inc), 32'd0);

      // PSA=1 out of reset: TMR0 sees its tick directly
      rst_n = 1'b1;
      tmr0_tick = 1'b1;
      #1;
      check("bypass_psa1", 32'(tmr0_inc), 32'd1);
      tmr0_tick = 1'b0;

      // PSA=1, PS=2: timeout 16 cycles after the OPTION write
      option_in = 6'b001010;
      option_we = 1'b1;
      cyc(1);
      option_we = 1'b0;
      cyc(15);
      check("to_boundary.rst_req", 32'(core_rst_req), 32'd0);
      check("to_boundary.prescale_cnt", 32'(prescale_cnt), 32'd3);
      cyc(1);
      check_outs("wdt_reset", 1'b1, 1'b1, 1'b0, 1'b1);
      check("wdt_reset.prescale_cnt", 32'(prescale_cnt), 32'd0);
      cyc(3);
      check("rst_hold_last", 32'(core_rst_req), 32'd1);
      cyc(1);
      check_outs("rst_release", 1'b0, 1'b0, 1'b0, 1'b1);

      // CLRWDT every 12 cycles keeps the watchdog quiet
      saw_req = 1'b0;
      for (int i = 0; i < 200; i++) begin
         ex_clrwdt = (i % 12 == 0);
         cyc(1);
         if (core_rst_req !== 1'b0) saw_req = 1'b1;
      end
      ex_clrwdt = 1'b0;
      check("clrwdt_loop.no_reset", 32'(saw_req), 32'd0);
      check_outs("clrwdt_loop", 1'b0, 1'b0, 1'b1, 1'b1);

      // SLEEP, then wake-up by watchdog timeout
      ex_sleep = 1'b1;
      cyc(1);
      ex_sleep = 1'b0;
      check_outs("sleep_entry", 1'b1, 1'b0, 1'b1, 1'b0);
      tmr0_tick = 1'b1;
      #1;
      check("sleep_tmr0_gate", 32'(tmr0_inc), 32'd0);
      tmr0_tick = 1'b0;
      cyc(15);
      check_outs("sleep_pre_to", 1'b1, 1'b0, 1'b1, 1'b0);
      cyc(1);
      check_outs("sleep_wake", 1'b1, 1'b1, 1'b0, 1'b0);
      cyc(3);
      check("sleep_hold_last", 32'(core_rst_req), 32'd1);
      cyc(1);
      check_outs("sleep_release", 1'b0, 1'b0, 1'b0, 1'b0);

      // CLRWDT in the very cycle of the timeout wins
      cyc(15);
      check("clr_vs_to.pre_cnt", 32'(prescale_cnt), 32'd3);
      ex_clrwdt = 1'b1;
      cyc(1);
      ex_clrwdt = 1'b0;
      check_outs("clr_vs_to", 1'b0, 1'b0, 1'b1, 1'b1);
      check("clr_vs_to.prescale_cnt", 32'(prescale_cnt), 32'd0);
      cyc(15);
      check("clr_vs_to.next_pre", 32'(core_rst_req), 32'd0);
      cyc(1);
      check("clr_vs_to.next_to", 32'(core_rst_req), 32'd1);

      // rst_n in the middle of the RESET hold
      cyc(1);
      rst_n = 1'b0;
      cyc(1);
      check_outs("rst_mid_reset", 1'b0, 1'b0, 1'b1, 1'b1);
      check("rst_mid_reset.prescale_cnt", 32'(prescale_cnt), 32'd0);

      // PSA=0, PS=1 with the watchdog disabled: 16 ticks give 4 increments
      wdt_en = 1'b0;
      cyc(1);
      rst_n = 1'b1;
      option_in = 6'b000001;
      option_we = 1'b1;
      cyc(1);
      option_we = 1'b0;
      n_inc = 0;
      for (int i = 0; i < 16; i++) begin
         tmr0_tick = 1'b1;
         #1;
         if (tmr0_inc === 1'b1) n_inc++;
         cyc(1);
      end
      tmr0_tick = 1'b0;
      check("psa0_inc_count", 32'(n_inc), 32'd4);
      check("psa0.prescale_cnt", 32'(prescale_cnt), 32'd0);
      check("psa0.rst_req", 32'(core_rst_req), 32'd0);

      // OPTION write colliding with the TMR0 terminal count
      tmr0_tick = 1'b1;
      cyc(3);
      check("we_vs_term.pre_cnt", 32'(prescale_cnt), 32'd3);
      option_we = 1'b1;
      #1;
      check("we_vs_term.tmr0_inc", 32'(tmr0_inc), 32'd0);
      cyc(1);
      option_we = 1'b0;
      tmr0_tick = 1'b0;
      check("we_vs_term.prescale_cnt", 32'(prescale_cnt), 32'd0);

      // SLEEP without watchdog never wakes on its own
      ex_sleep = 1'b1;
      cyc(1);
      ex_sleep = 1'b0;
      cyc(40);
      check_outs("sleep_no_wdt", 1'b1, 1'b0, 1'b1, 1'b0);

      // PSA=0: every base tick is a timeout, 4 cycles apart
      rst_n = 1'b0;
      wdt_en = 1'b1;
      cyc(1);
      rst_n = 1'b1;
      option_in = 6'b000001;
      option_we = 1'b1;
      cyc(1);
      option_we = 1'b0;
      cyc(3);
      check("psa0_to.pre", 32'(core_rst_req), 32'd0);
      cyc(1);
      check_outs("psa0_to", 1'b1, 1'b1, 1'b0, 1'b1);
      cyc(4);
      check("psa0_to.release", 32'(core_rst_req), 32'd0);
      cyc(3);
      check("psa0_to2.pre", 32'(core_rst_req), 32'd0);
      cyc(1);
      check("psa0_to2", 32'(core_rst_req), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
